// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared sizes, state type and window-start helper for hif_queue_ctrl
package queue_pkg;

  localparam int DEPTH_DEF = 1536;
  localparam int FRAME_DEF = 1531;
  localparam int PTR_W     = 11;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_IDLE,
    ST_SEQ,
    ST_DONE
  } state_t;

  // Oldest address of a FRAME-long window ending at 'last', modulo depth without 2^PTR_W wrap.
  function automatic logic [PTR_W-1:0] win_start(input logic [PTR_W-1:0] last,
                                                 input int depth, input int frame);
    if (last >= PTR_W'(frame - 1))
      win_start = last - PTR_W'(frame - 1);
    else
      win_start = last + PTR_W'(depth - frame + 1);
  endfunction

endpackage

// File: rtl/hif_queue_ctrl_if.sv
// rtl/hif_queue_ctrl_if.sv - sample strobe in, RAM/ROM addressing and status out
interface hif_queue_ctrl_if;
  import queue_pkg::*;

  logic             wrt_smpl;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [PTR_W-1:0] raddr;
  logic             sequencing;
  logic             rd_vld;
  logic [PTR_W-1:0] coeff_addr;
  logic             seq_done;
  logic             primed;
  logic             overrun;

  modport master (
    input  wrt_smpl,
    output we, waddr, raddr, sequencing, rd_vld, coeff_addr, seq_done, primed, overrun
  );

  modport slave (
    output wrt_smpl,
    input  we, waddr, raddr, sequencing, rd_vld, coeff_addr, seq_done, primed, overrun
  );

endinterface

// File: rtl/circ_ptr.sv
// rtl/circ_ptr.sv - modulo-DEPTH pointer with synchronous load and increment
module circ_ptr
  import queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PTR_W-1:0] load_val,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (inc)
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/hif_queue_ctrl.sv
// rtl/hif_queue_ctrl.sv - circular sample buffer write/read sequencer; HIF_QUEUE_CTRL_OVERRUN_EN adds sticky overrun
module hif_queue_ctrl
  import queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int FRAME = FRAME_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  hif_queue_ctrl_if.master bus
);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wptr, raddr_q, coeff_q, wr_cnt, waddr_q;
  logic             we_q, pending, primed_q, rd_vld_q;
  logic             last_seq, fill_done, seq_load, seq_step, pending_set;

  assign last_seq  = (coeff_q == PTR_W'(FRAME - 1));
  assign fill_done = (state == ST_FILL) && we_q && (wr_cnt == PTR_W'(FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_FILL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (fill_done) state_nxt = ST_SEQ;
      ST_IDLE: if (we_q)      state_nxt = ST_SEQ;
      ST_SEQ:  if (last_seq)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = pending ? ST_SEQ : ST_IDLE;
      default: state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    bus.sequencing = (state == ST_SEQ);
    bus.seq_done   = (state == ST_DONE);
  end

  assign seq_load = (state_nxt == ST_SEQ) && (state != ST_SEQ);
  assign seq_step = (state == ST_SEQ) && !last_seq;
  // A sample whose write lands in SEQ or DONE is missing from the running window and needs another pass.
  assign pending_set = bus.wrt_smpl && ((state_nxt == ST_SEQ) || (state_nxt == ST_DONE));

  circ_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .inc      (bus.wrt_smpl),
    .ptr      (wptr)
  );

  circ_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seq_load),
    .load_val (win_start(waddr_q, DEPTH, FRAME)),
    .inc      (seq_step),
    .ptr      (raddr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wr_cnt   <= '0;
      coeff_q  <= '0;
      pending  <= 1'b0;
      primed_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      we_q     <= bus.wrt_smpl;
      rd_vld_q <= (state == ST_SEQ);
      if (bus.wrt_smpl)
        waddr_q <= wptr;
      if ((state == ST_FILL) && we_q)
        wr_cnt <= wr_cnt + 1'b1;
      if (fill_done)
        primed_q <= 1'b1;
      if (seq_load)
        coeff_q <= '0;
      else if (seq_step)
        coeff_q <= coeff_q + 1'b1;
      pending <= pending_set || (pending && (state != ST_DONE));
    end
  end

`ifdef HIF_QUEUE_CTRL_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_q <= 1'b0;
    else if (bus.wrt_smpl && pending)
      overrun_q <= 1'b1;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.raddr      = raddr_q;
  assign bus.coeff_addr = coeff_q;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.primed     = primed_q;

endmodule

// File: tb/tb_hif_queue_ctrl.sv
// tb/tb_hif_queue_ctrl.sv - directed bench for hif_queue_ctrl
module tb_hif_queue_ctrl;

  localparam int DEPTH = 1536;
  localparam int FRAME = 1531;
`ifdef HIF_QUEUE_CTRL_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wp = 0;
  logic prev_seq = 1'b0;

  hif_queue_ctrl_if bus ();

  hif_queue_ctrl #(.DEPTH(DEPTH), .FRAME(FRAME)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with wrt_smpl=w; the resulting write is checked against the bench's own pointer.
  task automatic step(input logic w);
    bus.wrt_smpl = w;
    tick();
    check("we", 32'(bus.we), 32'(w));
    if (w) begin
      check("waddr", 32'(bus.waddr), 32'(wp));
      wp = (wp + 1) % DEPTH;
    end
  endtask

  task automatic do_seq(input int start, input int ncyc, input int inj_a, input int inj_b);
    for (int j = 0; j < ncyc; j++) begin
      check("seq_flags", 32'({bus.sequencing, bus.seq_done}), 32'd2);
      check("raddr", 32'(bus.raddr), 32'((start + j) % DEPTH));
      check("coeff_addr", 32'(bus.coeff_addr), 32'(j));
      step(j == inj_a || j == inj_b);
    end
    if (ncyc == FRAME)
      check("seq_done", 32'({bus.sequencing, bus.seq_done}), 32'd1);
  endtask

  task automatic do_reset();
    bus.wrt_smpl = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_waddr", 32'(bus.waddr), 32'd0);
    check("rst_raddr", 32'(bus.raddr), 32'd0);
    check("rst_sequencing", 32'(bus.sequencing), 32'd0);
    check("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
    check("rst_coeff_addr", 32'(bus.coeff_addr), 32'd0);
    check("rst_seq_done", 32'(bus.seq_done), 32'd0);
    check("rst_primed", 32'(bus.primed), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wp = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n)
      check("rd_vld", 32'(bus.rd_vld), 32'(prev_seq));
    prev_seq = bus.sequencing;
  end

  initial begin
    bus.wrt_smpl = 1'b0;
    do_reset();

    // Fill from reset: writes 0..1530, window 0..1530
    for (int i = 0; i < FRAME; i++) step(1'b1);
    check("fill_primed", 32'(bus.primed), 32'd0);
    check("fill_seq", 32'(bus.sequencing), 32'd0);
    step(1'b0);
    check("primed", 32'(bus.primed), 32'd1);
    do_seq(0, FRAME, -1, -1);
    step(1'b0);
    check("idle_flags", 32'({bus.sequencing, bus.seq_done}), 32'd0);
    check("raddr_hold", 32'(bus.raddr), 32'd1530);
    check("coeff_hold", 32'(bus.coeff_addr), 32'd1530);

    // Write 1531 -> window 1..1531; mid-SEQ write 1532 -> back-to-back window 2..1532
    step(1'b1);
    step(1'b0);
    do_seq(1, FRAME, 100, -1);
    step(1'b0);
    do_seq(2, FRAME, -1, -1);
    step(1'b0);
    check("idle_flags2", 32'({bus.sequencing, bus.seq_done}), 32'd0);
    check("overrun_single", 32'(bus.overrun), 32'd0);

    // Write 1533 -> window 3..; two writes (1534, 1535) in one SEQ -> overrun when enabled
    step(1'b1);
    step(1'b0);
    do_seq(3, FRAME, 10, 20);
    check("overrun_set", 32'(bus.overrun), 32'(OVR));
    step(1'b0);
    do_seq(5, FRAME, -1, -1);
    check("overrun_sticky", 32'(bus.overrun), 32'(OVR));
    step(1'b0);

    // Pointer wrapped: write at 0, window 6..1535,0
    step(1'b1);
    step(1'b0);
    do_seq(6, FRAME, -1, -1);
    step(1'b0);

    // Write at 1 -> window starts at 7; reset at SEQ cycle 700
    step(1'b1);
    step(1'b0);
    do_seq(7, 700, -1, -1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      check("post_rst_flags", 32'({bus.sequencing, bus.seq_done}), 32'd0);
    end
    for (int i = 0; i < FRAME - 1; i++) step(1'b1);
    step(1'b0);
    check("refill_primed", 32'(bus.primed), 32'd0);
    check("refill_seq", 32'(bus.sequencing), 32'd0);
    step(1'b1);
    step(1'b0);
    check("refill_primed2", 32'(bus.primed), 32'd1);
    do_seq(0, FRAME, -1, -1);
    step(1'b0);
    check("final_flags", 32'({bus.sequencing, bus.seq_done}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
